// File: rtl/instr_sequencer.sv
// Instruction fetch sequencer: prefetches from a synchronous ROM and holds each word for its class's slot length.
// Optional single-step mode (step input, PAUSE state) is enabled by defining SEQ_SINGLE_STEP_EN.
module instr_sequencer #(
    parameter int INSTR_WIDTH = 20,
    parameter int ADDR_BITS   = 5,
    parameter int STD_CYCLES  = 3,
    parameter int MEM_CYCLES  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic                   step,
`endif
    output logic [ADDR_BITS-1:0]   imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [ADDR_BITS-1:0]   pc,
    output logic                   slot_start,
    output logic                   busy,
    output logic                   done,
    output logic [7:0]             retired
);

    localparam int MAX_CYC = (STD_CYCLES > MEM_CYCLES) ? STD_CYCLES : MEM_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRIME  = 3'd1,
        S_RUN    = 3'd2,
`ifdef SEQ_SINGLE_STEP_EN
        S_PAUSE  = 3'd4,
`endif
        S_HALTED = 3'd3
    } state_t;

    state_t                 state_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [ADDR_BITS-1:0]   imem_addr_r;
    logic [1:0]             cls_s;
    logic                   is_halt_s;
    logic                   load_s;
    logic [CNT_W-1:0]       load_cnt_s;
    logic [ADDR_BITS-1:0]   next_pc_s;

    // Slot-boundary decode: whether this edge captures a word, and what the new slot looks like.
    always_comb begin
        cls_s     = imem_data[INSTR_WIDTH-1 -: 2];
        is_halt_s = (cls_s == 2'b00);
        if (cls_s == 2'b01) begin
            load_cnt_s = CNT_W'(STD_CYCLES - 1);
        end else begin
            load_cnt_s = CNT_W'(MEM_CYCLES - 1);
        end
        if (state_r == S_PRIME) begin
            next_pc_s = {ADDR_BITS{1'b0}};
        end else begin
            next_pc_s = pc + ADDR_BITS'(1);
        end
        case (state_r)
            S_PRIME: load_s = 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
            S_PAUSE: load_s = step;
            S_RUN:   load_s = 1'b0;
`else
            S_RUN:   load_s = (cnt_r == {CNT_W{1'b0}});
`endif
            default: load_s = 1'b0;
        endcase
    end

    // Restarting from HALTED must fetch word 0 in the start cycle, otherwise PRIME would see ROM[pc].
    assign imem_addr = ((state_r == S_HALTED) && start) ? {ADDR_BITS{1'b0}} : imem_addr_r;

    // Sequencer state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            imem_addr_r <= {ADDR_BITS{1'b0}};
            instr       <= {INSTR_WIDTH{1'b0}};
            pc          <= {ADDR_BITS{1'b0}};
            slot_start  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            retired     <= 8'd0;
        end else if (load_s) begin
            instr      <= imem_data;
            pc         <= next_pc_s;
            slot_start <= 1'b1;
            if (is_halt_s) begin
                state_r     <= S_HALTED;
                imem_addr_r <= next_pc_s;
                busy        <= 1'b0;
                done        <= 1'b1;
            end else begin
                state_r     <= S_RUN;
                cnt_r       <= load_cnt_s;
                imem_addr_r <= next_pc_s + ADDR_BITS'(1);
                retired     <= (retired == 8'd255) ? 8'd255 : retired + 8'd1;
            end
        end else begin
            case (state_r)
                S_IDLE, S_HALTED: begin
                    slot_start <= 1'b0;
                    if (start) begin
                        state_r     <= S_PRIME;
                        pc          <= {ADDR_BITS{1'b0}};
                        retired     <= 8'd0;
                        imem_addr_r <= {ADDR_BITS{1'b0}};
                        busy        <= 1'b1;
                        done        <= 1'b0;
                    end
                end
                S_RUN: begin
                    slot_start <= 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_r <= S_PAUSE;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
`else
                    cnt_r <= cnt_r - CNT_W'(1);
`endif
                end
`ifdef SEQ_SINGLE_STEP_EN
                S_PAUSE: begin
                    slot_start <= 1'b0;
                end
`endif
                default: begin
                    state_r    <= S_IDLE;
                    slot_start <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule
